nios_security_failsafe_pio: RTL and testbench
=============================================

Name: nios_security_failsafe_pio

Overview:
- Parametrised Avalon-MM output port for the security subsystem.
- Successor to the single-register STOP/PIO outputs: WIDTH-bit output register with atomic set/clear access and a built-in watchdog.
- If the Nios stops refreshing the port, the watchdog forces the outputs to a parameterised failsafe pattern (e.g. STOP asserted). It latches that state and raises an interrupt until software acknowledges it.

Parameters:
WIDTH, 32, output port width (1..32); unused readdata bits read 0
RESET_VALUE, 0, data_out value after reset
SAFE_VALUE, 1, data_out value forced on watchdog trip
TMR_WIDTH, 24, watchdog counter/reload width (1..32)
TIMEOUT_DEFAULT, 5000000, reset value of TIMEOUT register (100 ms at 50 MHz)

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous assert, active-low
address  input  3  Avalon word address
chipselect  input  1  Avalon select
write_n  input  1  Avalon write strobe, active-low
writedata  input  32  Avalon write data
readdata  output  32  Avalon read data, zero wait-state, combinational from address
out_port  output  WIDTH  registered output pins (= data_out)
irq  output  1  timeout_flag & irq_en

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values: data_out=RESET_VALUE, wdg_en=0, irq_en=0, timeout_flag=0, timeout_reg=TIMEOUT_DEFAULT, count=TIMEOUT_DEFAULT, irq=0.
- Write strobe: wr = chipselect & ~write_n. All register updates take effect on the clk edge where wr is sampled.
- Register map:
  - 0 DATA (RW): data_out <= writedata[WIDTH-1:0].
  - 1 STATUS (R; W1C bit0): bit0 timeout_flag, bit1 wdg_en.
  - 2 CONTROL (RW): bit0 wdg_en, bit1 irq_en.
  - 3 TIMEOUT (RW): timeout_reg <= writedata[TMR_WIDTH-1:0].
  - 4 OUTSET (WO, reads 0): data_out <= data_out | wd.
  - 5 OUTCLR (WO, reads 0): data_out <= data_out & ~wd.
  - 6 KICK (WO, reads 0): data ignored.
  - 7 COUNT (RO): current count, zero-extended.
- Kick events: any write to DATA, OUTSET, OUTCLR or KICK is a kick. Each kick reloads count <= timeout_reg.
- Other reload events:
  - writing CONTROL with bit0=1 while wdg_en=0;
  - writing TIMEOUT (reloads with the new value);
  - clearing timeout_flag.
- Countdown: when wdg_en=1, timeout_flag=0, count!=0 and no reload event, count decrements by 1 per cycle. Otherwise count holds.
- Trip: when wdg_en=1, timeout_flag=0 and count==0 at an edge:
  - timeout_flag <= 1;
  - data_out <= SAFE_VALUE.
- Trip timing: trip occurs T+1 edges after the reloading edge (T = timeout_reg). T=0 trips on the edge after reload.
- Trip vs simultaneous kick: the trip wins. The kick's data_out update and its reload are both discarded.
- Tripped state (timeout_flag=1):
  - writes to DATA, OUTSET and OUTCLR are ignored; data_out holds SAFE_VALUE;
  - KICK has no effect;
  - CONTROL and TIMEOUT writes still update their registers.
- Acknowledge: writing STATUS with bit0=1 clears timeout_flag and reloads count. data_out stays SAFE_VALUE until software writes it.
- Watchdog disabled: clearing wdg_en stops counting, never trips, and does not clear an existing timeout_flag.
- Reset mid-operation (asynchronous): all state returns to reset values immediately, including a tripped state.
- Width rules:
  - writedata bits above WIDTH and TMR_WIDTH are ignored;
  - readdata upper bits are 0;
  - an unmapped or write-only read returns 0.
- irq is combinational from registers; no extra latency.

Test Plan:
- Reset, then read all addresses -> out_port=0, readdata[1]=0, readdata[2]=0, readdata[3]=5000000, readdata[7]=5000000, irq=0.
- Write DATA=0xA5, OUTSET=0x0A, OUTCLR=0x01 -> out_port=0xA5, then 0xAF, then 0xAE. Read addr 0 = 0xAE.
- TIMEOUT=10, CONTROL=3, no further writes -> trip on edge 11 after the CONTROL write. Expected: out_port=0x1, STATUS=0x3, irq=1, COUNT=0.
- Tripped: write DATA=0xFF -> out_port stays 0x1. Write STATUS=1 -> irq=0, COUNT=10. Write DATA=0xFF -> out_port=0xFF.
- TIMEOUT=4, CONTROL=1, KICK every 4 cycles for 100 cycles -> no trip. Place a DATA write on the exact trip edge -> trip wins, out_port=SAFE_VALUE.
- Assert reset_n=0 mid-count while tripped -> out_port=RESET_VALUE and irq=0 immediately without a clock edge. Registers return to reset values.

Source files
------------

// File: rtl/nios_security_failsafe_pio_if.sv
// Avalon-MM slave bus bundle for the failsafe PIO: address, strobes, and
// the zero wait-state read/write data paths.
interface nios_security_failsafe_pio_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/nios_security_failsafe_pio.sv
// Security-subsystem output port with atomic set/clear access and a watchdog.
// If software stops kicking, the outputs are forced to SAFE_VALUE and the
// tripped state is latched (with optional irq) until software acknowledges it.
module nios_security_failsafe_pio #(
   parameter int unsigned WIDTH           = 32,
   parameter logic [31:0] RESET_VALUE     = 32'd0,
   parameter logic [31:0] SAFE_VALUE      = 32'd1,
   parameter int unsigned TMR_WIDTH       = 24,
   parameter logic [31:0] TIMEOUT_DEFAULT = 32'd5000000
) (
   input  logic                          clk,
   input  logic                          reset_n,
   nios_security_failsafe_pio_if.slave   bus,
   output logic [WIDTH-1:0]              out_port,
   output logic                          irq
);

   typedef enum logic [2:0] {
      REG_DATA    = 3'd0,
      REG_STATUS  = 3'd1,
      REG_CONTROL = 3'd2,
      REG_TIMEOUT = 3'd3,
      REG_OUTSET  = 3'd4,
      REG_OUTCLR  = 3'd5,
      REG_KICK    = 3'd6,
      REG_COUNT   = 3'd7
   } reg_addr_e;

   localparam logic [WIDTH-1:0]     RST_DATA  = RESET_VALUE[WIDTH-1:0];
   localparam logic [WIDTH-1:0]     SAFE_DATA = SAFE_VALUE[WIDTH-1:0];
   localparam logic [TMR_WIDTH-1:0] TO_DEF    = TIMEOUT_DEFAULT[TMR_WIDTH-1:0];

   logic [WIDTH-1:0]     data_out, data_nxt;
   logic [TMR_WIDTH-1:0] timeout_reg, timeout_nxt;
   logic [TMR_WIDTH-1:0] count, count_nxt;
   logic                 wdg_en, wdg_en_nxt;
   logic                 irq_en, irq_en_nxt;
   logic                 timeout_flag, flag_nxt;

   reg_addr_e            addr;
   logic                 wr;
   logic [WIDTH-1:0]     wd;
   logic [TMR_WIDTH-1:0] wd_tmr;
   logic                 trip, ack, kick, ctrl_wr, tmo_wr, enable_wr;
   logic [31:0]          rdata;
   logic                 unused_wdata;

   assign addr   = reg_addr_e'(bus.address);
   assign wr     = bus.chipselect & ~bus.write_n;
   assign wd     = bus.writedata[WIDTH-1:0];
   assign wd_tmr = bus.writedata[TMR_WIDTH-1:0];
   assign unused_wdata = ^bus.writedata;

   // Decode write events and watchdog conditions.
   always_comb begin
      trip      = wdg_en & ~timeout_flag & (count == '0);
      ack       = wr & (addr == REG_STATUS) & bus.writedata[0] & timeout_flag;
      ctrl_wr   = wr & (addr == REG_CONTROL);
      tmo_wr    = wr & (addr == REG_TIMEOUT);
      enable_wr = ctrl_wr & bus.writedata[0] & ~wdg_en;
      kick      = wr & ~timeout_flag &
                  ((addr == REG_DATA) | (addr == REG_OUTSET) |
                   (addr == REG_OUTCLR) | (addr == REG_KICK));
   end

   // Next-state logic; a trip overrides any same-edge kick (data and reload).
   always_comb begin
      data_nxt    = data_out;
      timeout_nxt = timeout_reg;
      count_nxt   = count;
      wdg_en_nxt  = wdg_en;
      irq_en_nxt  = irq_en;
      flag_nxt    = timeout_flag;

      if (trip) begin
         flag_nxt = 1'b1;
         data_nxt = SAFE_DATA;
      end else if (ack) begin
         flag_nxt = 1'b0;
      end

      if (!trip && !timeout_flag && wr) begin
         case (addr)
            REG_DATA:   data_nxt = wd;
            REG_OUTSET: data_nxt = data_out | wd;
            REG_OUTCLR: data_nxt = data_out & ~wd;
            default:    ;
         endcase
      end

      if (ctrl_wr) begin
         wdg_en_nxt = bus.writedata[0];
         irq_en_nxt = bus.writedata[1];
      end

      if (tmo_wr) begin
         timeout_nxt = wd_tmr;
      end

      if (tmo_wr) begin
         count_nxt = wd_tmr;
      end else if (ack || enable_wr || (kick && !trip)) begin
         count_nxt = timeout_reg;
      end else if (wdg_en && !timeout_flag && (count != '0)) begin
         count_nxt = count - TMR_WIDTH'(1);
      end
   end

   // Register state; reset is asynchronous so a tripped port releases at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out     <= RST_DATA;
         timeout_reg  <= TO_DEF;
         count        <= TO_DEF;
         wdg_en       <= 1'b0;
         irq_en       <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         data_out     <= data_nxt;
         timeout_reg  <= timeout_nxt;
         count        <= count_nxt;
         wdg_en       <= wdg_en_nxt;
         irq_en       <= irq_en_nxt;
         timeout_flag <= flag_nxt;
      end
   end

   // Zero wait-state read mux; write-only and unused bits read as zero.
   always_comb begin
      rdata = '0;
      case (addr)
         REG_DATA:    rdata[WIDTH-1:0]     = data_out;
         REG_STATUS:  rdata[1:0]           = {wdg_en, timeout_flag};
         REG_CONTROL: rdata[1:0]           = {irq_en, wdg_en};
         REG_TIMEOUT: rdata[TMR_WIDTH-1:0] = timeout_reg;
         REG_COUNT:   rdata[TMR_WIDTH-1:0] = count;
         default:     ;
      endcase
   end

   assign bus.readdata = rdata;
   assign out_port     = data_out;
   assign irq          = timeout_flag & irq_en;

endmodule

// File: tb/tb_nios_security_failsafe_pio.sv
// Bench for nios_security_failsafe_pio: register-access vector table plus
// hand-written watchdog trip, kick, acknowledge and reset sequences.
module tb_nios_security_failsafe_pio;

   logic        clk;
   logic        reset_n;
   logic [31:0] out_port;
   logic        irq;

   nios_security_failsafe_pio_if bus ();

   nios_security_failsafe_pio #(
      .WIDTH           (32),
      .RESET_VALUE     (32'd0),
      .SAFE_VALUE      (32'd1),
      .TMR_WIDTH       (24),
      .TIMEOUT_DEFAULT (32'd5000000)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus.slave),
      .out_port (out_port),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [2:0]  addr;
      logic [31:0] data;
      logic [31:0] exp_rd;
      logic [31:0] exp_out;
      logic        exp_irq;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] value;
   } exp_t;

   localparam int NV = 15;
   vec_t vecs [NV];
   exp_t sb [$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic expect_v(input string nm, input logic [31:0] v);
      exp_t e;
      e.name  = nm;
      e.value = v;
      sb.push_back(e);
   endtask

   task automatic sample(input logic [31:0] act);
      exp_t e;
      n_total++;
      if (sb.size() == 0) begin
         $display("FAIL scoreboard_empty: got 0x%08h with no expected value", act);
      end else begin
         e = sb.pop_front();
         if (act === e.value) n_pass++;
         else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.value);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      expect_v(nm, exp);
      sample(act);
   endtask

   task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
      bus.address = a;
      #1;
      chk(nm, bus.readdata, exp);
   endtask

   task automatic wr_op(input logic [2:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(posedge clk);
      #1;
      bus.write_n    = 1'b1;
      bus.chipselect = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b0, 3'd0, 32'h0,         32'h0,        32'h0,  1'b0};
      vecs[1]  = '{1'b0, 3'd1, 32'h0,         32'h0,        32'h0,  1'b0};
      vecs[2]  = '{1'b0, 3'd2, 32'h0,         32'h0,        32'h0,  1'b0};
      vecs[3]  = '{1'b0, 3'd3, 32'h0,         32'd5000000,  32'h0,  1'b0};
      vecs[4]  = '{1'b0, 3'd7, 32'h0,         32'd5000000,  32'h0,  1'b0};
      vecs[5]  = '{1'b1, 3'd0, 32'h0000_00A5, 32'h0000_00A5, 32'hA5, 1'b0};
      vecs[6]  = '{1'b1, 3'd4, 32'h0000_000A, 32'h0,        32'hAF, 1'b0};
      vecs[7]  = '{1'b1, 3'd5, 32'h0000_0001, 32'h0,        32'hAE, 1'b0};
      vecs[8]  = '{1'b0, 3'd0, 32'h0,         32'h0000_00AE, 32'hAE, 1'b0};
      vecs[9]  = '{1'b1, 3'd3, 32'hFF00_0010, 32'h0000_0010, 32'hAE, 1'b0};
      vecs[10] = '{1'b0, 3'd7, 32'h0,         32'h0000_0010, 32'hAE, 1'b0};
      vecs[11] = '{1'b1, 3'd6, 32'h0000_1234, 32'h0,        32'hAE, 1'b0};
      vecs[12] = '{1'b1, 3'd3, 32'h0000_000A, 32'h0000_000A, 32'hAE, 1'b0};
      vecs[13] = '{1'b0, 3'd7, 32'h0,         32'h0000_000A, 32'hAE, 1'b0};
      vecs[14] = '{1'b1, 3'd1, 32'h0000_0001, 32'h0,        32'hAE, 1'b0};

      reset_n        = 1'b0;
      bus.address    = 3'd0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle(1);

      // Register map, watchdog disabled: count must hold between vectors.
      for (int i = 0; i < NV; i++) begin
         bus.address    = vecs[i].addr;
         bus.writedata  = vecs[i].data;
         bus.chipselect = 1'b1;
         bus.write_n    = ~vecs[i].wr;
         expect_v($sformatf("vec%0d out_port", i), vecs[i].exp_out);
         expect_v($sformatf("vec%0d readdata", i), vecs[i].exp_rd);
         expect_v($sformatf("vec%0d irq", i), {31'd0, vecs[i].exp_irq});
         @(posedge clk);
         #1;
         bus.write_n = 1'b1;
         #1;
         sample(out_port);
         sample(bus.readdata);
         sample({31'd0, irq});
      end
      bus.chipselect = 1'b0;

      // TIMEOUT=10 already loaded; enable watchdog and irq, let it expire.
      wr_op(3'd2, 32'h3);
      chk("enable irq", {31'd0, irq}, 32'h0);
      for (int k = 1; k <= 10; k++) begin
         idle(1);
         rd_chk($sformatf("countdown k%0d", k), 3'd7, 32'(10 - k));
      end
      chk("pre-trip irq", {31'd0, irq}, 32'h0);
      chk("pre-trip out", out_port, 32'hAE);
      idle(1);
      chk("trip out", out_port, 32'h1);
      chk("trip irq", {31'd0, irq}, 32'h1);
      rd_chk("trip status", 3'd1, 32'h3);
      rd_chk("trip count", 3'd7, 32'h0);

      wr_op(3'd0, 32'hFF);
      chk("tripped data ignored", out_port, 32'h1);
      wr_op(3'd1, 32'h1);
      chk("ack irq", {31'd0, irq}, 32'h0);
      chk("ack out holds safe", out_port, 32'h1);
      rd_chk("ack count reload", 3'd7, 32'd10);
      wr_op(3'd0, 32'hFF);
      chk("post-ack data", out_port, 32'hFF);

      // Periodic kicking keeps a T=4 watchdog from tripping.
      wr_op(3'd2, 32'h0);
      wr_op(3'd3, 32'h4);
      wr_op(3'd2, 32'h1);
      for (int i = 0; i < 25; i++) begin
         idle(3);
         wr_op(3'd6, 32'h0);
         rd_chk($sformatf("kick%0d status", i), 3'd1, 32'h2);
      end
      chk("kick out", out_port, 32'hFF);
      idle(4);
      rd_chk("edge count zero", 3'd7, 32'h0);
      rd_chk("edge status", 3'd1, 32'h2);
      wr_op(3'd0, 32'h55);
      chk("trip beats data write", out_port, 32'h1);
      rd_chk("trip beats status", 3'd1, 32'h3);
      rd_chk("trip beats no reload", 3'd7, 32'h0);
      chk("trip irq masked", {31'd0, irq}, 32'h0);

      // Disabling the watchdog leaves an existing trip latched.
      wr_op(3'd2, 32'h0);
      rd_chk("disable keeps flag", 3'd1, 32'h1);
      idle(20);
      rd_chk("disabled flag holds", 3'd1, 32'h1);
      wr_op(3'd2, 32'h2);
      chk("late irq enable", {31'd0, irq}, 32'h1);
      wr_op(3'd2, 32'h3);
      rd_chk("tripped enable reload", 3'd7, 32'h4);
      idle(3);
      rd_chk("tripped count holds", 3'd7, 32'h4);

      // Asynchronous reset between clock edges.
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async reset out", out_port, 32'h0);
      chk("async reset irq", {31'd0, irq}, 32'h0);
      rd_chk("reset status", 3'd1, 32'h0);
      rd_chk("reset control", 3'd2, 32'h0);
      rd_chk("reset timeout", 3'd3, 32'd5000000);
      rd_chk("reset count", 3'd7, 32'd5000000);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      idle(1);

      // T=0 trips on the edge right after the reload.
      wr_op(3'd3, 32'h0);
      wr_op(3'd2, 32'h1);
      rd_chk("t0 status", 3'd1, 32'h2);
      rd_chk("t0 count", 3'd7, 32'h0);
      idle(1);
      rd_chk("t0 trip status", 3'd1, 32'h3);
      chk("t0 trip out", out_port, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
